// File: rtl/voice_allocator.sv
// Note-event controller for an 8-voice synthesizer: allocates voices to incoming
// note events (free voice, retrigger, or round-robin steal) and runs per-voice linear envelopes.
module voice_allocator #(
  parameter int unsigned N_VOICES     = 8,
  parameter logic [31:0] VOL_MAX      = 32'h0000_4000,
  parameter logic [31:0] ATTACK_STEP  = 32'h0000_0100,
  parameter logic [31:0] RELEASE_STEP = 32'h0000_0040,
  parameter int unsigned TICK_DIV     = 1000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [6:0]                   ev_note,
  input  logic [31:0]                  ev_freq,
  output logic [N_VOICES-1:0][31:0]    frequencies,
  output logic [N_VOICES-1:0][31:0]    voice_volumes,
  output logic [N_VOICES-1:0]          voice_active
);

  localparam int unsigned IW = $clog2(N_VOICES);
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {V_FREE, V_ATTACK, V_SUSTAIN, V_RELEASE} vstate_e;
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_e;

  state_e                      state_q, state_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic                        ev_on_q, ev_on_d;
  logic [6:0]                  ev_note_q, ev_note_d;
  logic [31:0]                 ev_freq_q, ev_freq_d;
  logic                        free_found_q, free_found_d;
  logic [IW-1:0]               free_idx_q, free_idx_d;
  logic                        as_found_q, as_found_d;
  logic [IW-1:0]               as_idx_q, as_idx_d;
  logic                        rel_found_q, rel_found_d;
  logic [IW-1:0]               rel_idx_q, rel_idx_d;
  logic [IW-1:0]               steal_ptr_q, steal_ptr_d;
  logic [TW-1:0]               tick_cnt_q, tick_cnt_d;
  vstate_e                     vst_q [N_VOICES];
  vstate_e                     vst_d [N_VOICES];
  logic [N_VOICES-1:0][6:0]    vnote_q, vnote_d;
  logic [N_VOICES-1:0][31:0]   vfreq_q, vfreq_d;
  logic [N_VOICES-1:0][31:0]   vvol_q, vvol_d;
  logic                        ev_ready_q, ev_ready_d;
  logic [N_VOICES-1:0]         active_q, active_d;

  logic                        tick;
  logic [32:0]                 att_sum;
  logic                        cm_en, cm_alloc;
  vstate_e                     cm_state;
  logic [IW-1:0]               tgt;

  assign ev_ready      = ev_ready_q;
  assign frequencies   = vfreq_q;
  assign voice_volumes = vvol_q;
  assign voice_active  = active_q;

  // Controller, envelope and commit next-state logic
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ev_on_d      = ev_on_q;
    ev_note_d    = ev_note_q;
    ev_freq_d    = ev_freq_q;
    free_found_d = free_found_q;
    free_idx_d   = free_idx_q;
    as_found_d   = as_found_q;
    as_idx_d     = as_idx_q;
    rel_found_d  = rel_found_q;
    rel_idx_d    = rel_idx_q;
    steal_ptr_d  = steal_ptr_q;
    vst_d        = vst_q;
    vnote_d      = vnote_q;
    vfreq_d      = vfreq_q;
    vvol_d       = vvol_q;
    att_sum      = '0;
    cm_en        = 1'b0;
    cm_alloc     = 1'b0;
    cm_state     = V_FREE;
    tgt          = '0;

    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

    for (int i = 0; i < N_VOICES; i++) begin
      if (tick) begin
        case (vst_q[i])
          V_ATTACK: begin
            att_sum = {1'b0, vvol_q[i]} + {1'b0, ATTACK_STEP};
            if (att_sum >= {1'b0, VOL_MAX}) begin
              vvol_d[i] = VOL_MAX;
              vst_d[i]  = V_SUSTAIN;
            end else begin
              vvol_d[i] = att_sum[31:0];
            end
          end
          V_RELEASE: begin
            if (vvol_q[i] <= RELEASE_STEP) begin
              vvol_d[i] = '0;
              vst_d[i]  = V_FREE;
            end else begin
              vvol_d[i] = vvol_q[i] - RELEASE_STEP;
            end
          end
          default: ;
        endcase
      end
    end

    case (state_q)
      S_IDLE: begin
        if (ev_valid && ev_ready_q) begin
          ev_on_d      = ev_on;
          ev_note_d    = ev_note;
          ev_freq_d    = ev_freq;
          free_found_d = 1'b0;
          as_found_d   = 1'b0;
          rel_found_d  = 1'b0;
          idx_d        = '0;
          state_d      = S_SCAN;
        end
      end
      S_SCAN: begin
        if (vst_q[idx_q] == V_FREE && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        if ((vst_q[idx_q] == V_ATTACK || vst_q[idx_q] == V_SUSTAIN) &&
            vnote_q[idx_q] == ev_note_q && !as_found_q) begin
          as_found_d = 1'b1;
          as_idx_d   = idx_q;
        end
        if (ev_on_q && vst_q[idx_q] == V_RELEASE && vnote_q[idx_q] == ev_note_q &&
            !rel_found_q) begin
          rel_found_d = 1'b1;
          rel_idx_d   = idx_q;
        end
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(N_VOICES - 1)) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        if (ev_on_q) begin
          cm_en    = 1'b1;
          cm_state = V_ATTACK;
          if (as_found_q)       tgt = as_idx_q;
          else if (rel_found_q) tgt = rel_idx_q;
          else begin
            cm_alloc = 1'b1;
            if (free_found_q) tgt = free_idx_q;
            else begin
              tgt         = steal_ptr_q;
              steal_ptr_d = steal_ptr_q + IW'(1);
            end
          end
        end else if (as_found_q) begin
          cm_en    = 1'b1;
          cm_state = V_RELEASE;
          tgt      = as_idx_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The committed voice overrides any tick update in the same cycle
    if (cm_en) begin
      vst_d[tgt]   = cm_state;
      vvol_d[tgt]  = cm_alloc ? 32'h0 : vvol_q[tgt];
      vfreq_d[tgt] = ev_on_q ? ev_freq_q : vfreq_q[tgt];
      if (cm_alloc) vnote_d[tgt] = ev_note_q;
    end

    ev_ready_d = (state_d == S_IDLE);
    for (int i = 0; i < N_VOICES; i++) active_d[i] = (vst_d[i] != V_FREE);
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      ev_on_q      <= 1'b0;
      ev_note_q    <= '0;
      ev_freq_q    <= '0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      as_found_q   <= 1'b0;
      as_idx_q     <= '0;
      rel_found_q  <= 1'b0;
      rel_idx_q    <= '0;
      steal_ptr_q  <= '0;
      tick_cnt_q   <= '0;
      for (int i = 0; i < N_VOICES; i++) vst_q[i] <= V_FREE;
      vnote_q      <= '0;
      vfreq_q      <= '0;
      vvol_q       <= '0;
      ev_ready_q   <= 1'b1;
      active_q     <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ev_on_q      <= ev_on_d;
      ev_note_q    <= ev_note_d;
      ev_freq_q    <= ev_freq_d;
      free_found_q <= free_found_d;
      free_idx_q   <= free_idx_d;
      as_found_q   <= as_found_d;
      as_idx_q     <= as_idx_d;
      rel_found_q  <= rel_found_d;
      rel_idx_q    <= rel_idx_d;
      steal_ptr_q  <= steal_ptr_d;
      tick_cnt_q   <= tick_cnt_d;
      vst_q        <= vst_d;
      vnote_q      <= vnote_d;
      vfreq_q      <= vfreq_d;
      vvol_q       <= vvol_d;
      ev_ready_q   <= ev_ready_d;
      active_q     <= active_d;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed table, corner sequences and
// randomized events compared every cycle against an event-level reference model.
module tb_voice_allocator;
  localparam int TD = 10;
  localparam longint VMAX = 64'h4000, ASTEP = 64'h100, RSTEP = 64'h40;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ev_valid = 1'b0, ev_on = 1'b0;
  logic [6:0] ev_note = '0;
  logic [31:0] ev_freq = '0;
  logic ev_ready;
  logic [7:0][31:0] frequencies, voice_volumes;
  logic [7:0] voice_active;

  always #5 clk = ~clk;

  voice_allocator #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset_n(reset_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_note(ev_note), .ev_freq(ev_freq),
    .frequencies(frequencies), .voice_volumes(voice_volumes), .voice_active(voice_active)
  );

  int checks = 0, failures = 0;

  // Reference model: 0 free, 1 attack, 2 sustain, 3 release
  int m_vs [8];
  logic [6:0] m_note [8];
  logic [31:0] m_freq [8];
  longint m_vol [8];
  int m_tcnt, m_age, m_steal, fr_i, as_i, rl_i;
  bit m_pend, m_on;
  logic [6:0] m_evnote;
  logic [31:0] m_evfreq;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_vs[i] = 0; m_note[i] = '0; m_freq[i] = '0; m_vol[i] = 0;
    end
    m_tcnt = 0; m_age = 0; m_steal = 0; m_pend = 0;
    fr_i = -1; as_i = -1; rl_i = -1;
  endtask

  task automatic model_edge();
    bit tick;
    int tgt, kind, k;
    tick = (m_tcnt == TD - 1);
    tgt = -1; kind = 0;
    if (m_pend && m_age >= 1 && m_age <= 8) begin
      k = m_age - 1;
      if (m_vs[k] == 0 && fr_i < 0) fr_i = k;
      if ((m_vs[k] == 1 || m_vs[k] == 2) && m_note[k] == m_evnote && as_i < 0) as_i = k;
      if (m_on && m_vs[k] == 3 && m_note[k] == m_evnote && rl_i < 0) rl_i = k;
    end
    if (m_pend && m_age == 9) begin
      if (m_on) begin
        if (as_i >= 0) begin tgt = as_i; kind = 2; end
        else if (rl_i >= 0) begin tgt = rl_i; kind = 2; end
        else if (fr_i >= 0) begin tgt = fr_i; kind = 1; end
        else begin tgt = m_steal; kind = 1; m_steal = (m_steal + 1) % 8; end
      end else if (as_i >= 0) begin
        tgt = as_i; kind = 3;
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (tick && i != tgt) begin
        if (m_vs[i] == 1) begin
          m_vol[i] = (m_vol[i] + ASTEP >= VMAX) ? VMAX : m_vol[i] + ASTEP;
          if (m_vol[i] == VMAX) m_vs[i] = 2;
        end else if (m_vs[i] == 3) begin
          m_vol[i] = (m_vol[i] <= RSTEP) ? 0 : m_vol[i] - RSTEP;
          if (m_vol[i] == 0) m_vs[i] = 0;
        end
      end
    end
    if (kind == 1) begin
      m_vs[tgt] = 1; m_vol[tgt] = 0; m_note[tgt] = m_evnote; m_freq[tgt] = m_evfreq;
    end else if (kind == 2) begin
      m_vs[tgt] = 1; m_freq[tgt] = m_evfreq;
    end else if (kind == 3) begin
      m_vs[tgt] = 3;
    end
    m_tcnt = tick ? 0 : m_tcnt + 1;
    if (m_pend) begin
      if (m_age == 9) m_pend = 0;
      else m_age++;
    end else if (ev_valid) begin
      m_pend = 1; m_age = 1; m_on = ev_on; m_evnote = ev_note; m_evfreq = ev_freq;
      fr_i = -1; as_i = -1; rl_i = -1;
    end
  endtask

  task automatic check_outputs();
    logic [7:0][31:0] ef, ev;
    logic [7:0] ea;
    for (int i = 0; i < 8; i++) begin
      ef[i] = m_freq[i]; ev[i] = 32'(m_vol[i]); ea[i] = (m_vs[i] != 0);
    end
    checks++;
    if (ev_ready !== !m_pend || voice_active !== ea || frequencies !== ef || voice_volumes !== ev) begin
      failures++;
      $display("FAIL model_cycle t=%0t ready=%b/%b active=%h/%h freq=%h/%h vol=%h/%h",
               $time, ev_ready, !m_pend, voice_active, ea, frequencies, ef, voice_volumes, ev);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; ev_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    check_outputs();
  endtask

  // Waits for ready (bounded), then presents the event for exactly the accept cycle
  task automatic send(input bit on, input logic [6:0] note, input logic [31:0] freq);
    int guard = 0;
    while (m_pend && guard < 50) begin cyc(); guard++; end
    if (m_pend) chk("send_ready_timeout", 64'(m_pend), 64'd0);
    ev_valid = 1'b1; ev_on = on; ev_note = note; ev_freq = freq;
    cyc();
    ev_valid = 1'b0; ev_on = ~on; ev_note = 7'($urandom); ev_freq = $urandom;
  endtask

  typedef struct {
    bit on; logic [6:0] note; logic [31:0] freq; int voice; logic [7:0] act;
  } vec_t;
  vec_t tbl [10];

  initial begin
    int guard;
    longint pv;
    for (int i = 0; i < 10; i++) begin
      tbl[i].on = 1'b1;
      tbl[i].note = 7'(70 + i);
      tbl[i].freq = 32'h100 * (i + 1) + 32'h7;
      tbl[i].voice = i % 8;
      tbl[i].act = (i < 8) ? 8'((16'h1 << (i + 1)) - 1) : 8'hFF;
    end
    model_reset();

    // Reset state and single note-on / sustain / release
    do_reset();
    chk("reset_ready", 64'(ev_ready), 64'd1);
    chk("reset_active", 64'(voice_active), 64'd0);
    send(1'b1, 7'd60, 32'h1000);
    run(8);
    chk("busy_ready_low", 64'(ev_ready), 64'd0);
    cyc();
    chk("on_freq0", 64'(frequencies[0]), 64'h1000);
    chk("on_active", 64'(voice_active), 64'h01);
    chk("on_vol0_start", 64'(voice_volumes[0]), 64'd0);
    run(10);
    chk("attack_one_tick", 64'(voice_volumes[0]), 64'h100);
    run(640);
    chk("sustain_vol", 64'(voice_volumes[0]), 64'h4000);
    send(1'b0, 7'd60, 32'hDEAD);
    run(9);
    chk("release_start_freq", 64'(frequencies[0]), 64'h1000);
    run(2600);
    chk("release_done_vol", 64'(voice_volumes[0]), 64'd0);
    chk("release_done_active", 64'(voice_active), 64'd0);
    send(1'b0, 7'd61, 32'h0);
    run(9);
    chk("noop_off_ready", 64'(ev_ready), 64'd1);

    // Back-to-back note-ons with valid held high: fill, then steal 0 and 1
    do_reset();
    ev_valid = 1'b1;
    for (int v = 0; v < 10; v++) begin
      ev_on = tbl[v].on; ev_note = tbl[v].note; ev_freq = tbl[v].freq;
      cyc();
      for (int c = 0; c < 9; c++) begin
        ev_on = 1'($urandom); ev_note = 7'($urandom); ev_freq = $urandom;
        cyc();
      end
      chk("tbl_ready", 64'(ev_ready), 64'd1);
      chk("tbl_freq", 64'(frequencies[tbl[v].voice]), 64'(tbl[v].freq));
      chk("tbl_vol", 64'(voice_volumes[tbl[v].voice]), 64'd0);
      chk("tbl_active", 64'(voice_active), 64'(tbl[v].act));
    end
    ev_valid = 1'b0;
    run(5);

    // Retrigger a releasing voice at half volume
    do_reset();
    send(1'b1, 7'd60, 32'h1000);
    run(700);
    send(1'b0, 7'd60, 32'h0);
    guard = 0;
    while (voice_volumes[0] != 32'h2000 && guard < 3000) begin cyc(); guard++; end
    chk("reach_half_vol", 64'(guard < 3000), 64'd1);
    send(1'b1, 7'd60, 32'h2222);
    run(9);
    chk("retrig_freq", 64'(frequencies[0]), 64'h2222);
    chk("retrig_active", 64'(voice_active), 64'h01);
    chk("retrig_vol_kept", 64'(voice_volumes[0] >= 32'h1FC0 && voice_volumes[0] <= 32'h2000), 64'd1);
    run(30);

    // Commit coinciding with a tick
    do_reset();
    send(1'b1, 7'd10, 32'hA);
    run(100);
    guard = 0;
    while (m_tcnt != 0 && guard < 20) begin cyc(); guard++; end
    send(1'b1, 7'd11, 32'hB);
    run(8);
    pv = m_vol[0];
    cyc();
    chk("ctick_new_vol", 64'(voice_volumes[1]), 64'd0);
    chk("ctick_new_freq", 64'(frequencies[1]), 64'hB);
    chk("ctick_other_adv", 64'(voice_volumes[0]), 64'(pv + ASTEP));

    // Reset asserted mid-scan
    send(1'b1, 7'd5, 32'h55);
    run(3);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_active", 64'(voice_active), 64'd0);
    chk("async_rst_freq", 64'(frequencies[0] | frequencies[1]), 64'd0);
    chk("async_rst_vol", 64'(voice_volumes[0]), 64'd0);
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    check_outputs();
    run(30);
    chk("post_rst_active", 64'(voice_active), 64'd0);

    // Randomized events against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      ev_valid = 1'($urandom);
      ev_on = ($urandom_range(0, 2) != 0);
      ev_note = 7'($urandom_range(0, 11));
      ev_freq = $urandom;
      cyc();
    end
    ev_valid = 1'b0;
    run(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
